// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch sequencer and its queue.
package fetch_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

  // Sequential PC advance; wraps modulo 2^ADDR_W with no error indication.
  function automatic logic [ADDR_W-1:0] pc_advance(input logic [ADDR_W-1:0] pc,
                                                   input logic [ADDR_W-1:0] step);
    return pc + step;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetched {pc, instr} entries with synchronous flush.
// Head data reads zero while empty so no stale or X data leaks to decode.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  fetch_entry_t           i_wdata,
  output fetch_entry_t           o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == {CNT_W{1'b0}});
  assign o_count = r_count;
  assign o_head  = o_empty ? fetch_entry_t'('0) : r_mem[r_rd_ptr];

  // Guard push/pop so a misbehaving caller can never overrun or underrun.
  always_comb begin
    w_pop  = i_pop & ~o_empty;
    w_push = i_push & (~o_full | w_pop);
  end

  // Storage, pointers and occupancy; flush wins over any push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, drives the zero-latency ROM address,
// queues returned words with their PC and handles redirect and halt.
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          ADDRESS_WIDTH = 16,
  parameter int          DATA_WIDTH    = 32,
  parameter int unsigned RESET_PC      = 0,
  parameter int unsigned PC_STEP       = 4,
  parameter int          DEPTH         = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]    mem_instr,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  input  logic                     halt_req,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_instr,
  output logic [ADDRESS_WIDTH-1:0] out_pc,
  output logic                     halted
);

  fetch_state_t             r_state;
  fetch_state_t             w_state_nxt;
  logic [ADDRESS_WIDTH-1:0] r_fetch_pc;
  logic                     r_post_redir;
  logic                     w_enq;
  logic                     w_pop;
  logic                     w_space;
  logic                     w_full;
  logic                     w_empty;
  logic [$clog2(DEPTH):0]   w_count;
  fetch_entry_t             w_head;
  fetch_entry_t             w_wdata;

  assign mem_addr  = r_fetch_pc;
  assign out_valid = ~w_empty;
  assign out_pc    = w_head.pc;
  assign out_instr = w_head.instr;
  assign halted    = (r_state == HALT);
  assign w_pop     = out_valid & out_ready;
  assign w_space   = ~w_full | w_pop;
  assign w_wdata   = '{pc: r_fetch_pc, instr: mem_instr};

  // Next state and enqueue gating. The cycle right after a redirect always
  // fetches the target even if halt_req is high; the halt then takes effect.
  always_comb begin
    w_state_nxt = r_state;
    w_enq       = 1'b0;
    case (r_state)
      RUN: begin
        if (redirect_valid) begin
          w_state_nxt = RUN;
        end else if (halt_req && !r_post_redir) begin
          w_state_nxt = HALT;
        end else begin
          w_enq       = w_space;
          w_state_nxt = halt_req ? HALT : RUN;
        end
      end
      HALT: begin
        if (redirect_valid || !halt_req) begin
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = HALT;
        end
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  // FSM state and post-redirect marker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RUN;
      r_post_redir <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_post_redir <= redirect_valid;
    end
  end

  // Fetch PC: redirect has priority, otherwise advance on each enqueue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= ADDRESS_WIDTH'(RESET_PC);
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc;
    end else if (w_enq) begin
      r_fetch_pc <= pc_advance(r_fetch_pc, ADDRESS_WIDTH'(PC_STEP));
    end else begin
      r_fetch_pc <= r_fetch_pc;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_enq),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_wdata (w_wdata),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Occupancy is only needed internally through full/empty.
  logic w_count_unused;
  assign w_count_unused = ^w_count;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed testbench for instr_fetch_ctrl with a combinational ROM model.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] mem_addr;
  logic [31:0] mem_instr;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halt_req;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [15:0] out_pc;
  logic        halted;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // ROM preload: word i holds 0x1000_0000 + i, addressed by byte PC.
  function automatic logic [31:0] rom(input logic [15:0] a);
    return 32'h1000_0000 + {18'h0, a[15:2]};
  endfunction

  // Expected {out_valid, out_pc, out_instr} for a given head.
  function automatic logic [48:0] hexp(input logic v, input logic [15:0] pc);
    if (v) return {1'b1, pc, rom(pc)};
    else   return 49'h0;
  endfunction

  assign mem_instr = rom(mem_addr);

  instr_fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_addr       (mem_addr),
    .mem_instr      (mem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .halted         (halted)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset and release just after an edge; the next cycle is fetch cycle 0.
  task automatic do_reset(input logic rdy);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    halt_req       = 1'b0;
    out_ready      = rdy;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    halt_req       = 1'b0;
    out_ready      = 1'b1;
    #2;
    n_vec++;
    if ({out_valid, out_pc, out_instr, mem_addr, halted} !== 66'h0) begin
      $display("FAIL reset: got v=%b pc=%h in=%h addr=%h h=%b want all zero",
               out_valid, out_pc, out_instr, mem_addr, halted);
      n_err++;
    end
  endtask

  task automatic test_stream();
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if ({out_valid, out_pc, out_instr} !== hexp(1'b1, 16'(i * 4))) begin
        $display("FAIL stream[%0d]: got %h want %h", i,
                 {out_valid, out_pc, out_instr}, hexp(1'b1, 16'(i * 4)));
        n_err++;
      end
      n_vec++;
      if (mem_addr !== 16'((i + 1) * 4)) begin
        $display("FAIL stream_addr[%0d]: got %h want %h", i, mem_addr, 16'((i + 1) * 4));
        n_err++;
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++;
      if ({out_valid, out_pc, out_instr} !== hexp(1'b1, 16'h0000)) begin
        $display("FAIL bp_hold[%0d]: got %h want %h", i,
                 {out_valid, out_pc, out_instr}, hexp(1'b1, 16'h0000));
        n_err++;
      end
    end
    n_vec++;
    if (mem_addr !== 16'h0008) begin
      $display("FAIL bp_addr: got %h want 0008", mem_addr);
      n_err++;
    end
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      n_vec++;
      if ({out_valid, out_pc, out_instr} !== hexp(1'b1, 16'(i * 4))) begin
        $display("FAIL bp_resume[%0d]: got %h want %h", i,
                 {out_valid, out_pc, out_instr}, hexp(1'b1, 16'(i * 4)));
        n_err++;
      end
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    tick(); tick(); tick();
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0100;
    tick();
    redirect_valid = 1'b0;
    n_vec++;
    if ({out_valid, mem_addr} !== {1'b0, 16'h0100}) begin
      $display("FAIL redir_flush: got v=%b addr=%h want v=0 addr=0100", out_valid, mem_addr);
      n_err++;
    end
    tick();
    n_vec++;
    if ({out_valid, out_pc, out_instr} !== hexp(1'b1, 16'h0100)) begin
      $display("FAIL redir_target: got %h want %h",
               {out_valid, out_pc, out_instr}, hexp(1'b1, 16'h0100));
      n_err++;
    end
  endtask

  task automatic test_halt();
    do_reset(1'b1);
    tick(); tick();
    halt_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++;
      if ({halted, out_valid, mem_addr} !== {1'b1, 1'b0, 16'h0008}) begin
        $display("FAIL halt[%0d]: got h=%b v=%b addr=%h want h=1 v=0 addr=0008",
                 i, halted, out_valid, mem_addr);
        n_err++;
      end
    end
    halt_req = 1'b0;
    tick();
    n_vec++;
    if ({halted, out_valid, mem_addr} !== {1'b0, 1'b0, 16'h0008}) begin
      $display("FAIL halt_release: got h=%b v=%b addr=%h want h=0 v=0 addr=0008",
               halted, out_valid, mem_addr);
      n_err++;
    end
    tick();
    n_vec++;
    if ({out_valid, out_pc, out_instr} !== hexp(1'b1, 16'h0008)) begin
      $display("FAIL halt_resume: got %h want %h",
               {out_valid, out_pc, out_instr}, hexp(1'b1, 16'h0008));
      n_err++;
    end
  endtask

  task automatic test_halt_redirect();
    do_reset(1'b0);
    tick();
    halt_req = 1'b1;
    tick();
    n_vec++;
    if ({halted, out_valid, out_pc} !== {1'b1, 1'b1, 16'h0000}) begin
      $display("FAIL hr_halted: got h=%b v=%b pc=%h want h=1 v=1 pc=0000",
               halted, out_valid, out_pc);
      n_err++;
    end
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0040;
    tick();
    redirect_valid = 1'b0;
    n_vec++;
    if ({halted, out_valid, mem_addr} !== {1'b0, 1'b0, 16'h0040}) begin
      $display("FAIL hr_run: got h=%b v=%b addr=%h want h=0 v=0 addr=0040",
               halted, out_valid, mem_addr);
      n_err++;
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++;
      if ({halted, mem_addr, out_valid, out_pc, out_instr} !==
          {1'b1, 16'h0044, hexp(1'b1, 16'h0040)}) begin
        $display("FAIL hr_rehalt[%0d]: got h=%b addr=%h head=%h want h=1 addr=0044 head=%h",
                 i, halted, mem_addr, {out_valid, out_pc, out_instr}, hexp(1'b1, 16'h0040));
        n_err++;
      end
    end
    halt_req = 1'b0;
  endtask

  task automatic test_wrap();
    logic [15:0] exp_pc [3];
    exp_pc[0] = 16'hFFF8;
    exp_pc[1] = 16'hFFFC;
    exp_pc[2] = 16'h0000;
    do_reset(1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFF8;
    tick();
    redirect_valid = 1'b0;
    n_vec++;
    if ({out_valid, mem_addr} !== {1'b0, 16'hFFF8}) begin
      $display("FAIL wrap_start: got v=%b addr=%h want v=0 addr=fff8", out_valid, mem_addr);
      n_err++;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if ({out_valid, out_pc, out_instr} !== hexp(1'b1, exp_pc[i])) begin
        $display("FAIL wrap[%0d]: got %h want %h", i,
                 {out_valid, out_pc, out_instr}, hexp(1'b1, exp_pc[i]));
        n_err++;
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset(1'b1);
    tick(); tick();
    n_vec++;
    if ({out_valid, out_pc} !== {1'b1, 16'h0004}) begin
      $display("FAIL ar_pre: got v=%b pc=%h want v=1 pc=0004", out_valid, out_pc);
      n_err++;
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, out_pc, out_instr, mem_addr, halted} !== 66'h0) begin
      $display("FAIL ar_clear: got v=%b pc=%h in=%h addr=%h h=%b want all zero",
               out_valid, out_pc, out_instr, mem_addr, halted);
      n_err++;
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_vec++;
    if ({out_valid, out_pc, out_instr} !== hexp(1'b1, 16'h0000)) begin
      $display("FAIL ar_restart: got %h want %h",
               {out_valid, out_pc, out_instr}, hexp(1'b1, 16'h0000));
      n_err++;
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_halt_redirect();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
